// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// MCTRL_ORI_EN widens the ALU B-select to 3 bits and adds the ZeroImm source for ori.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11,
    StOriEx   = 4'd12,
    StOriWb   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef logic [2:0] alu_ctrl_t;
  localparam alu_ctrl_t ALU_AND = 3'b000;
  localparam alu_ctrl_t ALU_OR  = 3'b001;
  localparam alu_ctrl_t ALU_ADD = 3'b010;
  localparam alu_ctrl_t ALU_SUB = 3'b110;
  localparam alu_ctrl_t ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10,
    AluOpOr    = 2'b11
  } alu_op_t;

`ifdef MCTRL_ORI_EN
  localparam int unsigned SRCB_W = 3;
`else
  localparam int unsigned SRCB_W = 2;
`endif

  typedef logic [SRCB_W-1:0] srcb_t;
  localparam srcb_t SRCB_B      = srcb_t'(0);
  localparam srcb_t SRCB_FOUR   = srcb_t'(1);
  localparam srcb_t SRCB_IMM    = srcb_t'(2);
  localparam srcb_t SRCB_IMM_SH = srcb_t'(3);
`ifdef MCTRL_ORI_EN
  localparam srcb_t SRCB_ZIMM   = srcb_t'(4);
`endif

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus the funct field to the 3-bit ALU control code.
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned FN_W = 6
) (
  input  alu_op_t         alu_op_i,
  input  logic [FN_W-1:0] funct_i,
  output alu_ctrl_t       alu_ctrl_o,
  output logic            funct_illegal_o
);

  always_comb begin
    alu_ctrl_o      = ALU_ADD;
    funct_illegal_o = 1'b0;
    case (alu_op_i)
      AluOpAdd: alu_ctrl_o = ALU_ADD;
      AluOpSub: alu_ctrl_o = ALU_SUB;
      AluOpOr:  alu_ctrl_o = ALU_OR;
      AluOpFunct: begin
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          default: funct_illegal_o = 1'b1;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM sequencing the shared multicycle MIPS datapath.
// Define MCTRL_ORI_EN to add ori support (3-bit alu_srcB, ORIEX/ORIWB states).
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OP_W = 6,
  parameter int unsigned FN_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   opcode,
  input  logic [FN_W-1:0]   funct,
  input  logic              zero,
  output logic              iord,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              alu_srcA,
  output logic [SRCB_W-1:0] alu_srcB,
  output logic [1:0]        pc_src,
  output logic              pc_en,
  output logic [2:0]        alu_ctrl_sig,
  output logic              illegal
);

  state_t  state_q, state_d;
  logic    funct_bad_q, funct_bad_d;
  logic    pc_write, branch;
  alu_op_t alu_op;
  logic    funct_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StFetch;
      funct_bad_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct_bad_q <= funct_bad_d;
    end
  end

  // Kept apart from the main decode so the decoder feedback is not a block-level loop.
  always_comb begin
    alu_op = AluOpAdd;
    if (!reset) begin
      case (state_q)
        StExecute: alu_op = AluOpFunct;
        StBranch:  alu_op = AluOpSub;
`ifdef MCTRL_ORI_EN
        StOriEx:   alu_op = AluOpOr;
`endif
        default:   alu_op = AluOpAdd;
      endcase
    end
  end

  alu_decoder #(
    .FN_W(FN_W)
  ) u_alu_decoder (
    .alu_op_i       (alu_op),
    .funct_i        (funct),
    .alu_ctrl_o     (alu_ctrl_sig),
    .funct_illegal_o(funct_illegal)
  );

  always_comb begin
    state_d     = StFetch;
    funct_bad_d = funct_bad_q;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_srcA    = 1'b0;
    alu_srcB    = SRCB_B;
    pc_src      = 2'b00;
    pc_write    = 1'b0;
    branch      = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      StFetch: begin
        ir_write = 1'b1;
        alu_srcB = SRCB_FOUR;
        pc_write = 1'b1;
        state_d  = StDecode;
      end
      StDecode: begin
        alu_srcB = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StExecute;
          OP_BEQ:       state_d = StBranch;
          OP_ADDI:      state_d = StAddiEx;
          OP_J:         state_d = StJump;
`ifdef MCTRL_ORI_EN
          OP_ORI:       state_d = StOriEx;
`endif
          default: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_srcA = 1'b1;
        alu_srcB = SRCB_IMM;
        state_d  = (opcode == OP_LW) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        iord    = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      StExecute: begin
        alu_srcA    = 1'b1;
        illegal     = funct_illegal;
        funct_bad_d = funct_illegal;
        state_d     = StAluWb;
      end
      StAluWb: begin
        // An undecodable funct must not commit its result.
        reg_write = ~funct_bad_q;
        reg_dst   = 1'b1;
      end
      StBranch: begin
        alu_srcA = 1'b1;
        branch   = 1'b1;
        pc_src   = 2'b01;
      end
      StAddiEx: begin
        alu_srcA = 1'b1;
        alu_srcB = SRCB_IMM;
        state_d  = StAddiWb;
      end
      StAddiWb: reg_write = 1'b1;
      StJump: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
`ifdef MCTRL_ORI_EN
      StOriEx: begin
        alu_srcA = 1'b1;
        alu_srcB = SRCB_ZIMM;
        state_d  = StOriWb;
      end
      StOriWb: reg_write = 1'b1;
`endif
      default: state_d = StFetch;
    endcase

    // The register already sits in FETCH during reset; mask its outputs.
    if (reset) begin
      ir_write    = 1'b0;
      alu_srcB    = SRCB_B;
      pc_write    = 1'b0;
      illegal     = 1'b0;
      funct_bad_d = 1'b0;
    end
  end

  assign pc_en = ~reset & (pc_write | (branch & zero));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class state by state.
module tb_multicycle_ctrl;

`ifdef MCTRL_ORI_EN
  localparam int unsigned SB_W = 3;
`else
  localparam int unsigned SB_W = 2;
`endif
  localparam int unsigned OW = 14 + SB_W;

  localparam bit N = 1'b0;
  localparam bit Y = 1'b1;
  localparam logic [SB_W-1:0] SB_B  = SB_W'(0);
  localparam logic [SB_W-1:0] SB_4  = SB_W'(1);
  localparam logic [SB_W-1:0] SB_I  = SB_W'(2);
  localparam logic [SB_W-1:0] SB_IS = SB_W'(3);

  logic            clk = 1'b0;
  logic            reset;
  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic            zero;
  logic            iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_srcA;
  logic [SB_W-1:0] alu_srcB;
  logic [1:0]      pc_src;
  logic            pc_en;
  logic [2:0]      alu_ctrl_sig;
  logic            illegal;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(
    .OP_W(6),
    .FN_W(6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .iord        (iord),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_srcA    (alu_srcA),
    .alu_srcB    (alu_srcB),
    .pc_src      (pc_src),
    .pc_en       (pc_en),
    .alu_ctrl_sig(alu_ctrl_sig),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  wire [OW-1:0] obs = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_srcA,
                       alu_srcB, pc_src, pc_en, alu_ctrl_sig, illegal};

  function automatic logic [OW-1:0] mk(input bit io, input bit mw, input bit irw, input bit rd,
                                       input bit m2r, input bit rw, input bit sa,
                                       input logic [SB_W-1:0] sb, input logic [1:0] ps,
                                       input bit pe, input logic [2:0] acs, input bit ill);
    return {io, mw, irw, rd, m2r, rw, sa, sb, ps, pe, acs, ill};
  endfunction

  task automatic chk(input string tag, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check mid low phase, then advance to the next falling edge.
  task automatic st(input string tag, input logic [OW-1:0] exp);
    #1;
    chk(tag, exp);
    @(negedge clk);
  endtask

  logic [OW-1:0] e_zero, e_fetch, e_dec, e_dec_ill, e_memadr, e_memrd, e_memwb, e_memwr;
  logic [OW-1:0] e_aluwb, e_aluwb_sup, e_br_t, e_br_n, e_addiex, e_addiwb, e_jump;
  logic [5:0]    fn_tab [4];
  logic [2:0]    ac_tab [4];

  initial begin
    e_zero      = mk(N, N, N, N, N, N, N, SB_B,  2'b00, N, 3'b010, N);
    e_fetch     = mk(N, N, Y, N, N, N, N, SB_4,  2'b00, Y, 3'b010, N);
    e_dec       = mk(N, N, N, N, N, N, N, SB_IS, 2'b00, N, 3'b010, N);
    e_dec_ill   = mk(N, N, N, N, N, N, N, SB_IS, 2'b00, N, 3'b010, Y);
    e_memadr    = mk(N, N, N, N, N, N, Y, SB_I,  2'b00, N, 3'b010, N);
    e_memrd     = mk(Y, N, N, N, N, N, N, SB_B,  2'b00, N, 3'b010, N);
    e_memwb     = mk(N, N, N, N, Y, Y, N, SB_B,  2'b00, N, 3'b010, N);
    e_memwr     = mk(Y, Y, N, N, N, N, N, SB_B,  2'b00, N, 3'b010, N);
    e_aluwb     = mk(N, N, N, Y, N, Y, N, SB_B,  2'b00, N, 3'b010, N);
    e_aluwb_sup = mk(N, N, N, Y, N, N, N, SB_B,  2'b00, N, 3'b010, N);
    e_br_t      = mk(N, N, N, N, N, N, Y, SB_B,  2'b01, Y, 3'b110, N);
    e_br_n      = mk(N, N, N, N, N, N, Y, SB_B,  2'b01, N, 3'b110, N);
    e_addiex    = mk(N, N, N, N, N, N, Y, SB_I,  2'b00, N, 3'b010, N);
    e_addiwb    = mk(N, N, N, N, N, Y, N, SB_B,  2'b00, N, 3'b010, N);
    e_jump      = mk(N, N, N, N, N, N, N, SB_B,  2'b10, Y, 3'b010, N);
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};
    ac_tab = '{3'b010,    3'b110,    3'b000,    3'b001};

    reset  = 1'b1;
    opcode = 6'b000000;
    funct  = 6'b101010;
    zero   = 1'b0;
    @(negedge clk);
    st("reset", e_zero);
    reset = 1'b0;

    // R-type slt
    st("slt.fetch", e_fetch);
    st("slt.decode", e_dec);
    st("slt.execute", mk(N, N, N, N, N, N, Y, SB_B, 2'b00, N, 3'b111, N));
    st("slt.aluwb", e_aluwb);

    // Reset asserted mid-EXECUTE
    st("rst.fetch", e_fetch);
    st("rst.decode", e_dec);
    #1 chk("rst.execute", mk(N, N, N, N, N, N, Y, SB_B, 2'b00, N, 3'b111, N));
    #1 reset = 1'b1;
    #1 chk("rst.async", e_zero);
    @(negedge clk);
    #1 chk("rst.hold", e_zero);
    reset = 1'b0;
    st("rst.release", e_fetch);

    // lw
    opcode = 6'b100011;
    st("lw.decode", e_dec);
    st("lw.memadr", e_memadr);
    st("lw.memrd", e_memrd);
    st("lw.memwb", e_memwb);

    // sw
    opcode = 6'b101011;
    st("sw.fetch", e_fetch);
    st("sw.decode", e_dec);
    st("sw.memadr", e_memadr);
    st("sw.memwr", e_memwr);

    // beq taken, then not taken
    opcode = 6'b000100;
    zero   = 1'b1;
    st("beq1.fetch", e_fetch);
    st("beq1.decode", e_dec);
    st("beq1.branch", e_br_t);
    zero = 1'b0;
    st("beq0.fetch", e_fetch);
    st("beq0.decode", e_dec);
    st("beq0.branch", e_br_n);

    // j
    opcode = 6'b000010;
    st("j.fetch", e_fetch);
    st("j.decode", e_dec);
    st("j.jump", e_jump);

    // Illegal opcode: two cycles
    opcode = 6'b111111;
    st("ill.fetch", e_fetch);
    st("ill.decode", e_dec_ill);

    // Unknown funct: illegal in EXECUTE, write suppressed in ALUWB
    opcode = 6'b000000;
    funct  = 6'b000111;
    st("badfn.fetch", e_fetch);
    st("badfn.decode", e_dec);
    st("badfn.execute", mk(N, N, N, N, N, N, Y, SB_B, 2'b00, N, 3'b010, Y));
    st("badfn.aluwb", e_aluwb_sup);

    // Remaining funct codes
    for (int i = 0; i < 4; i++) begin
      funct = fn_tab[i];
      st($sformatf("fn%0d.fetch", i), e_fetch);
      st($sformatf("fn%0d.decode", i), e_dec);
      st($sformatf("fn%0d.execute", i),
         mk(N, N, N, N, N, N, Y, SB_B, 2'b00, N, ac_tab[i], N));
      st($sformatf("fn%0d.aluwb", i), e_aluwb);
    end

    // addi
    opcode = 6'b001000;
    st("addi.fetch", e_fetch);
    st("addi.decode", e_dec);
    st("addi.ex", e_addiex);
    st("addi.wb", e_addiwb);

    // ori
    opcode = 6'b001101;
    st("ori.fetch", e_fetch);
`ifdef MCTRL_ORI_EN
    st("ori.decode", e_dec);
    st("ori.ex", mk(N, N, N, N, N, N, Y, SB_W'(4), 2'b00, N, 3'b001, N));
    st("ori.wb", e_addiwb);
`else
    st("ori.decode", e_dec_ill);
`endif
    st("final.fetch", e_fetch);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
